// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and constants, also consumed by the decode stage.
package fetch_pkg;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;

    // An all-zero word marks the end of the program image.
    localparam logic [31:0] HALT_WORD = 32'h0000_0000;

    typedef enum logic {
        RUN,
        HALTED
    } fetch_state_t;

    typedef struct packed {
        logic [DATA_W-1:0] instr;
        logic [ADDR_W-1:0] pc;
        logic              valid;
    } ifid_t;

endpackage

// File: rtl/fetch_stage.sv
// Instruction fetch in front of a 1-cycle registered instruction memory.
// Drives the IF/ID register and handles stall, redirect and halt-on-zero.
module fetch_stage #(
    parameter int                ADDR_W   = fetch_pkg::ADDR_W,
    parameter int                DATA_W   = fetch_pkg::DATA_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                CNT_W    = 16
) (
    input  logic              Clk,
    input  logic              Rst_n,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_data,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [DATA_W-1:0] id_instr,
    output logic [ADDR_W-1:0] id_pc,
    output logic              id_valid,
    output logic              halted,
    output logic [CNT_W-1:0]  fetch_count
);
    import fetch_pkg::*;

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] rd_pc_q;
    logic              rd_v_q;
    logic              do_fetch;
    logic              halt_hit;

    // During a stall the memory re-reads the word already in flight so its
    // output stays put; redirect overrides both.
    assign imem_addr = redirect ? redirect_pc : (stall ? rd_pc_q : pc_q);
    assign halted    = (state_q == HALTED);

    always_ff @(posedge Clk) begin
        if (!Rst_n) state_q <= RUN;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        do_fetch = 1'b0;
        halt_hit = 1'b0;
        if (redirect) begin
            state_d = RUN;
        end else if (state_q == RUN && !stall) begin
            do_fetch = 1'b1;
            if (rd_v_q && imem_data == DATA_W'(HALT_WORD)) begin
                halt_hit = 1'b1;
                state_d  = HALTED;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            pc_q        <= RESET_PC;
            rd_pc_q     <= RESET_PC;
            rd_v_q      <= 1'b0;
            id_instr    <= '0;
            id_pc       <= '0;
            id_valid    <= 1'b0;
            fetch_count <= '0;
        end else if (redirect) begin
            rd_pc_q  <= redirect_pc;
            rd_v_q   <= 1'b1;
            pc_q     <= redirect_pc + 1'b1;
            id_valid <= 1'b0;
        end else if (do_fetch) begin
            rd_pc_q <= pc_q;
            rd_v_q  <= 1'b1;
            pc_q    <= pc_q + 1'b1;
            if (halt_hit) begin
                id_valid <= 1'b0;
            end else begin
                id_instr <= imem_data;
                id_pc    <= rd_pc_q;
                id_valid <= rd_v_q;
                if (rd_v_q && fetch_count != '1)
                    fetch_count <= fetch_count + 1'b1;
            end
        end else if (state_q == HALTED) begin
            id_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a registered memory model and a
// queue-based scoreboard checking every word decode accepts.
module tb_fetch_stage;

    typedef struct {
        logic [9:0]  pc;
        logic [31:0] instr;
    } exp_t;

    logic        Clk;
    logic        Rst_n, stall, redirect;
    logic [9:0]  redirect_pc, imem_addr, id_pc;
    logic [31:0] imem_data, id_instr;
    logic        id_valid, halted;
    logic [15:0] fetch_count;

    logic        Rst2_n, stall2, redirect2;
    logic [9:0]  redirect_pc2, imem_addr2, id_pc2;
    logic [31:0] imem_data2, id_instr2;
    logic        id_valid2, halted2;
    logic [15:0] fetch_count2;

    logic [31:0] mem  [1024];
    logic [31:0] mem2 [1024];
    exp_t        q[$];
    exp_t        q2[$];
    int          total = 0;
    int          bad = 0;

    fetch_stage dut (
        .Clk(Clk), .Rst_n(Rst_n), .imem_addr(imem_addr), .imem_data(imem_data),
        .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .id_instr(id_instr), .id_pc(id_pc), .id_valid(id_valid),
        .halted(halted), .fetch_count(fetch_count)
    );

    fetch_stage #(.RESET_PC(10'd1022)) dut2 (
        .Clk(Clk), .Rst_n(Rst2_n), .imem_addr(imem_addr2), .imem_data(imem_data2),
        .stall(stall2), .redirect(redirect2), .redirect_pc(redirect_pc2),
        .id_instr(id_instr2), .id_pc(id_pc2), .id_valid(id_valid2),
        .halted(halted2), .fetch_count(fetch_count2)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always @(posedge Clk) imem_data  <= mem[imem_addr];
    always @(posedge Clk) imem_data2 <= mem2[imem_addr2];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Decode accepts a word on any cycle it is valid and not stalled.
    always @(negedge Clk) begin
        if (Rst_n && id_valid && !stall) begin
            if (q.size() == 0) begin
                total++; bad++;
                $display("FAIL sb_unexpected: got pc %0d expected none", id_pc);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("sb_pc", {22'd0, id_pc}, {22'd0, e.pc});
                chk("sb_instr", id_instr, e.instr);
            end
        end
    end

    always @(negedge Clk) begin
        if (Rst2_n && id_valid2 && !stall2) begin
            if (q2.size() == 0) begin
                total++; bad++;
                $display("FAIL sb2_unexpected: got pc %0d expected none", id_pc2);
            end else begin
                exp_t e;
                e = q2.pop_front();
                chk("sb2_pc", {22'd0, id_pc2}, {22'd0, e.pc});
                chk("sb2_instr", id_instr2, e.instr);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic push(input logic [9:0] pc);
        exp_t e;
        e.pc = pc;
        e.instr = mem[pc];
        q.push_back(e);
    endtask

    task automatic push2(input logic [9:0] pc);
        exp_t e;
        e.pc = pc;
        e.instr = mem2[pc];
        q2.push_back(e);
    endtask

    task automatic chk_reset(input string nm);
        chk({nm, "_instr"}, id_instr, 32'd0);
        chk({nm, "_pc"}, {22'd0, id_pc}, 32'd0);
        chk({nm, "_valid"}, {31'd0, id_valid}, 32'd0);
        chk({nm, "_halted"}, {31'd0, halted}, 32'd0);
        chk({nm, "_count"}, {16'd0, fetch_count}, 32'd0);
    endtask

    task automatic load_prog();
        logic [31:0] prog [8];
        prog = '{32'h23E0_1500, 32'h23E1_1504, 32'h23E2_1508, 32'h23E3_150C,
                 32'h0022_2018, 32'h0064_2020, 32'h00A4_3022, 32'hAFE6_1510};
        for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
        for (int i = 0; i < 8; i++) mem[i] = prog[i];
    endtask

    task automatic run_reset();
        Rst_n = 1'b0;
        step();
    endtask

    initial begin
        Rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        Rst2_n = 1'b0; stall2 = 1'b0; redirect2 = 1'b0; redirect_pc2 = '0;
        for (int i = 0; i < 1024; i++) mem2[i] = 32'd0;

        // Straight-line program, halts on the zero word at address 8
        load_prog();
        step(); step();
        chk_reset("rst");
        for (int i = 0; i < 8; i++) push(i[9:0]);
        Rst_n = 1'b1;
        step();
        chk("first_bubble", {31'd0, id_valid}, 32'd0);
        step();
        chk("first_valid", {31'd0, id_valid}, 32'd1);
        chk("first_pc", {22'd0, id_pc}, 32'd0);
        for (int k = 1; k < 8; k++) step();
        chk("line_pc7", {22'd0, id_pc}, 32'd7);
        step();
        chk("line_halted", {31'd0, halted}, 32'd1);
        chk("line_valid0", {31'd0, id_valid}, 32'd0);
        chk("line_count", {16'd0, fetch_count}, 32'd8);
        step(); step();
        chk("line_stay_halted", {31'd0, halted}, 32'd1);
        chk("line_drain", q.size(), 32'd0);

        // Stall held for three edges while id_pc=4
        run_reset();
        for (int i = 0; i < 8; i++) push(i[9:0]);
        Rst_n = 1'b1;
        step(); step();
        for (int k = 0; k < 4; k++) step();
        chk("stall_pre_pc", {22'd0, id_pc}, 32'd4);
        stall = 1'b1;
        #1;
        chk("stall_addr0", {22'd0, imem_addr}, 32'd5);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("stall_pc", {22'd0, id_pc}, 32'd4);
            chk("stall_valid", {31'd0, id_valid}, 32'd1);
            chk("stall_addr", {22'd0, imem_addr}, 32'd5);
            chk("stall_count", {16'd0, fetch_count}, 32'd5);
        end
        stall = 1'b0;
        step();
        chk("stall_rel_pc", {22'd0, id_pc}, 32'd5);
        chk("stall_rel_count", {16'd0, fetch_count}, 32'd6);
        step(); step(); step();
        chk("stall_halted", {31'd0, halted}, 32'd1);
        chk("stall_end_count", {16'd0, fetch_count}, 32'd8);
        chk("stall_drain", q.size(), 32'd0);

        // Redirect to 14 while id_pc=2; word 3 never delivered
        mem[14] = 32'hC0DE_000E;
        mem[15] = 32'hC0DE_000F;
        run_reset();
        push(10'd0); push(10'd1); push(10'd2); push(10'd14); push(10'd15);
        Rst_n = 1'b1;
        step(); step(); step(); step();
        chk("redir_pre_pc", {22'd0, id_pc}, 32'd2);
        redirect = 1'b1; redirect_pc = 10'd14;
        #1;
        chk("redir_addr", {22'd0, imem_addr}, 32'd14);
        step();
        redirect = 1'b0;
        chk("redir_bubble", {31'd0, id_valid}, 32'd0);
        step();
        chk("redir_pc14", {22'd0, id_pc}, 32'd14);
        chk("redir_valid", {31'd0, id_valid}, 32'd1);
        step(); step();
        chk("redir_halted", {31'd0, halted}, 32'd1);
        chk("redir_count", {16'd0, fetch_count}, 32'd5);
        chk("redir_drain", q.size(), 32'd0);

        // Redirect and stall in the same cycle while id_pc=3
        load_prog();
        mem[8] = 32'h8888_0008;
        mem[9] = 32'h9999_0009;
        run_reset();
        push(10'd0); push(10'd1); push(10'd2); push(10'd8); push(10'd9);
        Rst_n = 1'b1;
        step(); step();
        for (int k = 0; k < 3; k++) step();
        chk("rs_pre_pc", {22'd0, id_pc}, 32'd3);
        stall = 1'b1; redirect = 1'b1; redirect_pc = 10'd8;
        #1;
        chk("rs_addr", {22'd0, imem_addr}, 32'd8);
        step();
        stall = 1'b0; redirect = 1'b0;
        chk("rs_bubble", {31'd0, id_valid}, 32'd0);
        step();
        chk("rs_pc8", {22'd0, id_pc}, 32'd8);
        chk("rs_valid", {31'd0, id_valid}, 32'd1);
        step(); step();
        chk("rs_halted", {31'd0, halted}, 32'd1);
        chk("rs_count", {16'd0, fetch_count}, 32'd6);
        chk("rs_drain", q.size(), 32'd0);

        // Reset for one cycle while id_pc=5
        load_prog();
        run_reset();
        for (int i = 0; i < 8; i++) push(i[9:0]);
        Rst_n = 1'b1;
        step(); step();
        for (int k = 0; k < 5; k++) step();
        chk("mid_pre_pc", {22'd0, id_pc}, 32'd5);
        Rst_n = 1'b0;
        step();
        chk_reset("mid_rst");
        q.delete();
        for (int i = 0; i < 8; i++) push(i[9:0]);
        Rst_n = 1'b1;
        step();
        chk("mid_bubble", {31'd0, id_valid}, 32'd0);
        step();
        chk("mid_restart_pc", {22'd0, id_pc}, 32'd0);
        chk("mid_restart_valid", {31'd0, id_valid}, 32'd1);
        for (int k = 0; k < 8; k++) step();
        chk("mid_halted", {31'd0, halted}, 32'd1);
        chk("mid_count", {16'd0, fetch_count}, 32'd8);
        chk("mid_drain", q.size(), 32'd0);

        // Address wrap from RESET_PC=1022, halt, then redirect to 0
        mem2[1022] = 32'h1111_03FE;
        mem2[1023] = 32'h2222_03FF;
        mem2[0]    = 32'h3333_0000;
        mem2[1]    = 32'h4444_0001;
        step();
        push2(10'd1022); push2(10'd1023); push2(10'd0); push2(10'd1);
        Rst2_n = 1'b1;
        step(); step();
        chk("wrap_pc1022", {22'd0, id_pc2}, 32'd1022);
        step();
        chk("wrap_pc1023", {22'd0, id_pc2}, 32'd1023);
        step();
        chk("wrap_pc0", {22'd0, id_pc2}, 32'd0);
        step(); step();
        chk("wrap_halted", {31'd0, halted2}, 32'd1);
        chk("wrap_count", {16'd0, fetch_count2}, 32'd4);
        step();
        chk("wrap_halt_valid", {31'd0, id_valid2}, 32'd0);
        redirect2 = 1'b1; redirect_pc2 = 10'd0;
        push2(10'd0); push2(10'd1);
        step();
        redirect2 = 1'b0;
        chk("resume_halted", {31'd0, halted2}, 32'd0);
        chk("resume_bubble", {31'd0, id_valid2}, 32'd0);
        step();
        chk("resume_pc0", {22'd0, id_pc2}, 32'd0);
        step(); step();
        chk("resume_halted2", {31'd0, halted2}, 32'd1);
        chk("resume_count", {16'd0, fetch_count2}, 32'd6);
        chk("wrap_drain", q2.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage directly upstream of instructionmemory; generates its 10-bit word address and consumes its 32-bit registered read data.
- The memory has exactly 1 cycle of read latency. This block tracks which address is in flight, supports stall, redirect and halt, and drives the IF/ID pipeline register (instr, pc, valid) into decode.

Parameters:
- ADDR_W, 10, word-address width; matches the 1024-word memory.
- DATA_W, 32, instruction width.
- RESET_PC, 0, first fetch address after reset.
- CNT_W, 16, width of the fetched-instruction counter.

Ports:
- Clk  in  1  clock; all state updates on posedge.
- Rst_n  in  1  reset; synchronous, active-low.
- imem_addr  out  ADDR_W  address to instructionmemory. Combinational: redirect ? redirect_pc : (stall ? rd_pc_q : pc_q).
- imem_data  in  DATA_W  registered read data from instructionmemory (saida).
- stall  in  1  decode hazard; hold the IF/ID register and PC.
- redirect  in  1  branch/jump taken; flush and refetch.
- redirect_pc  in  ADDR_W  target word address.
- id_instr  out  DATA_W  IF/ID instruction.
- id_pc  out  ADDR_W  address of id_instr.
- id_valid  out  1  id_instr is a real instruction.
- halted  out  1  fetch stopped on a zero word.
- fetch_count  out  CNT_W  valid instructions delivered; saturating.

Behaviour:
- Internal state: pc_q (next address to issue), rd_pc_q/rd_v_q (address whose data is on imem_data this cycle), FSM {RUN, HALTED}.
- Reset (Rst_n=0 at posedge):
  - pc_q=RESET_PC, rd_pc_q=RESET_PC, rd_v_q=0.
  - id_instr=0, id_pc=0, id_valid=0.
  - fetch_count=0, halted=0, state=RUN.
  - Reset mid-operation discards all in-flight data; nothing from before reset reaches the outputs.
- Priority each cycle: reset > redirect > halted > stall > normal.
- Normal (RUN, no stall, no redirect):
  - rd_pc_q<=pc_q, rd_v_q<=1, pc_q<=pc_q+1 (mod 2^ADDR_W; 1023 wraps to 0).
  - IF/ID <= {imem_data, rd_pc_q, rd_v_q}.
- Stall (RUN): pc_q, rd_pc_q, rd_v_q, IF/ID and fetch_count all hold.
  - imem_addr=rd_pc_q, so the memory re-reads the same word and imem_data stays stable across stalls of any length.
  - The cycle after release behaves as Normal with no lost or duplicated instruction.
- Redirect (any state, overrides stall):
  - imem_addr=redirect_pc; rd_pc_q<=redirect_pc, rd_v_q<=1, pc_q<=redirect_pc+1.
  - id_valid<=0, flushing the wrong-path word; state<=RUN, halted<=0.
  - Penalty is exactly 1 bubble.
- Halt detect (RUN, Normal path, rd_v_q=1, imem_data==0):
  - The zero word is not delivered: id_valid<=0.
  - state<=HALTED, halted<=1.
- HALTED: pc_q and rd_v_q freeze, id_valid=0; only reset or redirect leaves the state.
- Latency: the first valid instruction appears on id_* in the 2nd cycle after reset release. Steady state is 1 instruction/cycle.
- fetch_count increments when a word with valid=1 is loaded into IF/ID; it saturates at 2^CNT_W-1.
- A stall while rd_v_q=0 is legal and has no effect beyond the hold.

Decomposition:
- Package fetch_pkg holds:
  - ADDR_W, DATA_W constants.
  - HALT_WORD = 32'h0000_0000.
  - fetch_state_t enum {RUN, HALTED}.
  - ifid_t struct {instr, pc, valid} for reuse by the decode stage.
- Single module; no sub-module warranted. The next-address mux and the IF/ID register are each under 30 lines.

Test Plan:
- Straight-line: memory words 0..7 = the 4 lw / mul / add / sub / sw program (word0=32'h23E0_1500), rest 0 → id_pc 0..7 on consecutive cycles; first valid on cycle 2; then halted=1, id_valid=0, fetch_count=8.
- Stall: stall held 3 cycles while id_pc=4 → id_pc stays 4 with id_valid=1; imem_addr=5 throughout the stall; cycle after release id_pc=5; fetch_count unchanged during the stall.
- Redirect: redirect=1, redirect_pc=14 while id_pc=2 → next cycle id_valid=0, then id_pc=14,15,…; word at address 3 is never delivered.
- Redirect+stall same cycle: stall=1, redirect=1, redirect_pc=8 → redirect wins; imem_addr=8 that cycle; id_pc=8 delivered two cycles later.
- Wrap/halt-resume: RESET_PC=1022 with nonzero words at 1022, 1023, 0, 1, then zero at 2 → id_pc 1022, 1023, 0, 1 then halted. A subsequent redirect to 0 clears halted and refetches.
- Reset mid-run: Rst_n low for 1 cycle while id_pc=5 → next cycle all outputs at reset values; fetch restarts from RESET_PC.
